// File: rtl/apb_uart_fifo.sv
// APB-attached UART with TX and RX FIFOs, programmable baud divider, sticky
// error flags and a level interrupt. Single clock domain; RX line synchronised.
module apb_uart_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_RST   = 87
) (
  input  logic       i_Pclk,
  input  logic       i_Preset,
  input  logic [1:0] i_Paddr,
  input  logic       i_Psel,
  input  logic       i_Penable,
  input  logic       i_Pwrite,
  input  logic [7:0] i_Pwdata,
  output logic [7:0] o_Prdata,
  output logic       o_Pready,
  input  logic       i_Rx_Serial,
  output logic       o_Tx_Serial,
  output logic       o_Irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]        r_baud;
  logic [2:0]        r_ctrl;
  logic              r_overrun;
  logic              r_frameErr;
  logic              r_irq;

  logic [DATA_W-1:0] r_txMem [FIFO_DEPTH];
  logic [AW-1:0]     r_txWr;
  logic [AW-1:0]     r_txRd;
  logic [CW-1:0]     r_txCount;
  logic [DATA_W-1:0] r_rxMem [FIFO_DEPTH];
  logic [AW-1:0]     r_rxWr;
  logic [AW-1:0]     r_rxRd;
  logic [CW-1:0]     r_rxCount;

  state_t            r_txState;
  logic [7:0]        r_txCnt;
  logic [7:0]        r_txBaud;
  logic [BW-1:0]     r_txBit;
  logic [DATA_W-1:0] r_txShift;
  logic              r_tx;

  state_t            r_rxState;
  logic [7:0]        r_rxCnt;
  logic [7:0]        r_rxBaud;
  logic [BW-1:0]     r_rxBit;
  logic [DATA_W-1:0] r_rxShift;
  logic              r_rxMeta;
  logic              r_rxSync;
  logic              r_rxPrev;

  logic              w_access;
  logic              w_wrData;
  logic              w_wrBaud;
  logic              w_wrCtrl;
  logic              w_rdData;
  logic [7:0]        w_baudEff;
  logic              w_txFull;
  logic              w_txEmpty;
  logic              w_txPush;
  logic              w_txPop;
  logic              w_txBusy;
  logic              w_rxFull;
  logic              w_rxEmpty;
  logic              w_rxPush;
  logic              w_rxPop;
  logic              w_rxStopSample;
  logic              w_rxStopOk;
  logic              w_rxOverrun;
  logic              w_rxFrameErr;
  logic [7:0]        w_status;
  logic [7:0]        w_rxHeadExt;

  assign w_access  = i_Psel & i_Penable;
  assign w_wrData  = w_access & i_Pwrite & (i_Paddr == 2'd0);
  assign w_wrBaud  = w_access & i_Pwrite & (i_Paddr == 2'd2);
  assign w_wrCtrl  = w_access & i_Pwrite & (i_Paddr == 2'd3);
  assign w_rdData  = w_access & ~i_Pwrite & (i_Paddr == 2'd0);
  assign w_baudEff = (r_baud < 8'd2) ? 8'd2 : r_baud;

  assign w_txFull  = (r_txCount == FULL_CNT);
  assign w_txEmpty = (r_txCount == '0);
  assign w_rxFull  = (r_rxCount == FULL_CNT);
  assign w_rxEmpty = (r_rxCount == '0);
  assign w_txBusy  = (r_txState != S_IDLE);

  // A pop in the same cycle frees the slot, so a push into a full FIFO can still land.
  assign w_txPop   = (r_txState == S_IDLE) & r_ctrl[0] & ~w_txEmpty;
  assign w_txPush  = w_wrData & (~w_txFull | w_txPop);
  assign w_rxPop   = w_rdData & ~w_rxEmpty;

  assign w_rxStopSample = (r_rxState == S_STOP) & (r_rxCnt == r_rxBaud - 8'd1);
  assign w_rxStopOk     = w_rxStopSample & r_rxSync;
  assign w_rxFrameErr   = w_rxStopSample & ~r_rxSync;
  assign w_rxPush       = w_rxStopOk & (~w_rxFull | w_rxPop);
  assign w_rxOverrun    = w_rxStopOk & w_rxFull & ~w_rxPop;

  assign w_status    = {1'b0, w_txBusy, r_frameErr, r_overrun, w_rxEmpty, w_rxFull, w_txEmpty, w_txFull};
  assign o_Pready    = 1'b1;
  assign o_Tx_Serial = r_tx;
  assign o_Irq       = r_irq;

  always_comb begin
    w_rxHeadExt = '0;
    w_rxHeadExt[DATA_W-1:0] = r_rxMem[r_rxRd];
    o_Prdata = '0;
    if (w_access & ~i_Pwrite) begin
      case (i_Paddr)
        2'd0:    o_Prdata = w_rxEmpty ? 8'd0 : w_rxHeadExt;
        2'd1:    o_Prdata = w_status;
        2'd2:    o_Prdata = r_baud;
        default: o_Prdata = {5'd0, r_ctrl};
      endcase
    end
  end

  always_ff @(posedge i_Pclk or posedge i_Preset) begin
    if (i_Preset) begin
      r_baud     <= 8'(BAUD_RST);
      r_ctrl     <= '0;
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wrBaud) r_baud <= i_Pwdata;
      if (w_wrCtrl) r_ctrl <= i_Pwdata[2:0];
      // A new error event in the same cycle as the clear wins, so it is never lost.
      if (w_wrCtrl & i_Pwdata[3]) begin
        r_overrun  <= 1'b0;
        r_frameErr <= 1'b0;
      end
      if (w_rxOverrun)  r_overrun  <= 1'b1;
      if (w_rxFrameErr) r_frameErr <= 1'b1;
      r_irq <= r_ctrl[2] & (~w_rxEmpty | r_overrun | r_frameErr);
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (w_txPush) r_txMem[r_txWr] <= i_Pwdata[DATA_W-1:0];
    if (w_rxPush) r_rxMem[r_rxWr] <= r_rxShift;
  end

  always_ff @(posedge i_Pclk or posedge i_Preset) begin
    if (i_Preset) begin
      r_txWr    <= '0;
      r_txRd    <= '0;
      r_txCount <= '0;
      r_rxWr    <= '0;
      r_rxRd    <= '0;
      r_rxCount <= '0;
    end else begin
      if (w_txPush) r_txWr <= r_txWr + 1'b1;
      if (w_txPop)  r_txRd <= r_txRd + 1'b1;
      case ({w_txPush, w_txPop})
        2'b10:   r_txCount <= r_txCount + 1'b1;
        2'b01:   r_txCount <= r_txCount - 1'b1;
        default: r_txCount <= r_txCount;
      endcase
      if (w_rxPush) r_rxWr <= r_rxWr + 1'b1;
      if (w_rxPop)  r_rxRd <= r_rxRd + 1'b1;
      case ({w_rxPush, w_rxPop})
        2'b10:   r_rxCount <= r_rxCount + 1'b1;
        2'b01:   r_rxCount <= r_rxCount - 1'b1;
        default: r_rxCount <= r_rxCount;
      endcase
    end
  end

  // STOP lasts one clock short because the following IDLE cycle completes the stop bit.
  always_ff @(posedge i_Pclk or posedge i_Preset) begin
    if (i_Preset) begin
      r_txState <= S_IDLE;
      r_txCnt   <= '0;
      r_txBaud  <= 8'd2;
      r_txBit   <= '0;
      r_txShift <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_txState)
        S_IDLE: begin
          if (w_txPop) begin
            r_txState <= S_START;
            r_txShift <= r_txMem[r_txRd];
            r_txBaud  <= w_baudEff;
            r_txCnt   <= '0;
            r_tx      <= 1'b0;
          end
        end
        S_START: begin
          if (r_txCnt == r_txBaud - 8'd1) begin
            r_txState <= S_DATA;
            r_txCnt   <= '0;
            r_txBit   <= '0;
            r_tx      <= r_txShift[0];
            r_txShift <= r_txShift >> 1;
          end else begin
            r_txCnt <= r_txCnt + 8'd1;
          end
        end
        S_DATA: begin
          if (r_txCnt == r_txBaud - 8'd1) begin
            r_txCnt <= '0;
            if (r_txBit == LAST_BIT) begin
              r_txState <= S_STOP;
              r_tx      <= 1'b1;
            end else begin
              r_txBit   <= r_txBit + 1'b1;
              r_tx      <= r_txShift[0];
              r_txShift <= r_txShift >> 1;
            end
          end else begin
            r_txCnt <= r_txCnt + 8'd1;
          end
        end
        S_STOP: begin
          if (r_txCnt == r_txBaud - 8'd2) begin
            r_txState <= S_IDLE;
            r_txCnt   <= '0;
          end else begin
            r_txCnt <= r_txCnt + 8'd1;
          end
        end
        default: r_txState <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Pclk or posedge i_Preset) begin
    if (i_Preset) begin
      r_rxMeta  <= 1'b1;
      r_rxSync  <= 1'b1;
      r_rxPrev  <= 1'b1;
      r_rxState <= S_IDLE;
      r_rxCnt   <= '0;
      r_rxBaud  <= 8'd2;
      r_rxBit   <= '0;
      r_rxShift <= '0;
    end else begin
      r_rxMeta <= i_Rx_Serial;
      r_rxSync <= r_rxMeta;
      r_rxPrev <= r_rxSync;
      case (r_rxState)
        S_IDLE: begin
          if (r_ctrl[1] & r_rxPrev & ~r_rxSync) begin
            r_rxState <= S_START;
            r_rxBaud  <= w_baudEff;
            r_rxCnt   <= '0;
          end
        end
        S_START: begin
          if (r_rxCnt == (r_rxBaud >> 1) - 8'd1) begin
            r_rxCnt   <= '0;
            r_rxBit   <= '0;
            r_rxState <= r_rxSync ? S_IDLE : S_DATA;
          end else begin
            r_rxCnt <= r_rxCnt + 8'd1;
          end
        end
        S_DATA: begin
          if (r_rxCnt == r_rxBaud - 8'd1) begin
            r_rxCnt   <= '0;
            r_rxShift <= {r_rxSync, r_rxShift[DATA_W-1:1]};
            if (r_rxBit == LAST_BIT) r_rxState <= S_STOP;
            else                     r_rxBit   <= r_rxBit + 1'b1;
          end else begin
            r_rxCnt <= r_rxCnt + 8'd1;
          end
        end
        S_STOP: begin
          if (w_rxStopSample) begin
            r_rxState <= S_IDLE;
            r_rxCnt   <= '0;
          end else begin
            r_rxCnt <= r_rxCnt + 8'd1;
          end
        end
        default: r_rxState <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Self-checking bench for apb_uart_fifo: register table, directed UART frames,
// and a randomized phase scored against a queue-based model of the FIFOs and flags.
module tb_apb_uart_fifo;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int BAUD_RST   = 87;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] paddr = '0;
  logic       psel = 1'b0;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [7:0] pwdata = '0;
  logic [7:0] prdata;
  logic       pready;
  logic       rxSerial = 1'b1;
  logic       txSerial;
  logic       irq;

  int nChecks = 0;
  int nErrors = 0;

  typedef struct {
    logic       isWrite;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] expRd;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic       mOvr;
  logic       mFe;
  int         mBaud;

  always #5 clk = ~clk;

  apb_uart_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .BAUD_RST(BAUD_RST)) dut (
    .i_Pclk(clk), .i_Preset(rst), .i_Paddr(paddr), .i_Psel(psel), .i_Penable(penable),
    .i_Pwrite(pwrite), .i_Pwdata(pwdata), .o_Prdata(prdata), .o_Pready(pready),
    .i_Rx_Serial(rxSerial), .o_Tx_Serial(txSerial), .o_Irq(irq)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s got=0x%0h want=0x%0h", name, actual, expected);
    end
  endtask

  task automatic apbWrite(input logic [1:0] addr, input logic [7:0] data);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    @(negedge clk); penable = 1'b1;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apbRead(input logic [1:0] addr, output logic [7:0] data);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    @(negedge clk); penable = 1'b1;
    #2 data = prdata;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic readCheck(input logic [1:0] addr, input logic [7:0] exp, input string name);
    logic [7:0] rd;
    apbRead(addr, rd);
    checkOutput(name, rd, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.isWrite) apbWrite(v.addr, v.wdata);
    else readCheck(v.addr, v.expRd, v.name);
  endtask

  task automatic doReset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitTxStart(input int limit, output int waited, output bit found);
    found = 1'b0;
    waited = 0;
    while (waited < limit) begin
      @(negedge clk);
      if (txSerial == 1'b0) begin
        found = 1'b1;
        break;
      end
      waited++;
    end
  endtask

  // Checks every clock of a frame against the ideal waveform, plus the decoded byte.
  task automatic expectTxFrame(input logic [7:0] data, input int baud, input int limit,
                               input string name, output int gap);
    bit found;
    logic [9:0] pattern;
    logic [7:0] got;
    int bad;
    bad = 0;
    got = '0;
    pattern = {1'b1, data, 1'b0};
    waitTxStart(limit, gap, found);
    checkOutput({name, "_start"}, 32'(found), 32'd1);
    if (!found) return;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < baud; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clk);
        if (txSerial !== pattern[b]) bad++;
        if (c == baud / 2 && b >= 1 && b <= 8) got[b-1] = txSerial;
      end
    end
    checkOutput({name, "_data"}, 32'(got), 32'(data));
    checkOutput({name, "_timing"}, bad, 0);
  endtask

  task automatic sendRxFrame(input logic [7:0] data, input int baud, input bit stopBit);
    logic [9:0] p;
    p = {stopBit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      @(negedge clk); rxSerial = p[b];
      repeat (baud - 1) @(negedge clk);
    end
    @(negedge clk); rxSerial = 1'b1;
  endtask

  function automatic logic [7:0] modelStatus();
    return {1'b0, 1'b0, mFe, mOvr, rxq.size() == 0, rxq.size() == FIFO_DEPTH,
            txq.size() == 0, txq.size() == FIFO_DEPTH};
  endfunction

  initial begin
    int gap;
    bit found;
    int op;
    logic [7:0] rd;
    logic [7:0] data;
    logic [7:0] exp;
    logic [7:0] bytes5[5];

    vecs.push_back('{1'b1, 2'd2, 8'h10, 8'h00, "baud_w10"});
    vecs.push_back('{1'b0, 2'd2, 8'h00, 8'h10, "baud_r10"});
    vecs.push_back('{1'b1, 2'd2, 8'h00, 8'h00, "baud_w00"});
    vecs.push_back('{1'b0, 2'd2, 8'h00, 8'h00, "baud_r00"});
    vecs.push_back('{1'b1, 2'd2, 8'h01, 8'h00, "baud_w01"});
    vecs.push_back('{1'b0, 2'd2, 8'h00, 8'h01, "baud_r01"});
    vecs.push_back('{1'b1, 2'd3, 8'h0F, 8'h00, "ctrl_w0f"});
    vecs.push_back('{1'b0, 2'd3, 8'h00, 8'h07, "ctrl_r07"});
    vecs.push_back('{1'b0, 2'd1, 8'h00, 8'h0A, "status_idle"});
    vecs.push_back('{1'b0, 2'd0, 8'h00, 8'h00, "data_empty"});
    vecs.push_back('{1'b1, 2'd3, 8'h00, 8'h00, "ctrl_w00"});
    vecs.push_back('{1'b0, 2'd3, 8'h00, 8'h00, "ctrl_r00"});

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx", 32'(txSerial), 32'd1);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    checkOutput("pready", 32'(pready), 32'd1);
    checkOutput("prdata_idle", 32'(prdata), 32'd0);
    rst = 1'b0;
    readCheck(2'd1, 8'h0A, "rst_status");
    readCheck(2'd2, 8'(BAUD_RST), "rst_baud");
    readCheck(2'd3, 8'h00, "rst_ctrl");

    foreach (vecs[i]) applyStimulus(vecs[i]);

    $display("[TB] TX frame 0xA5 at BAUD=4 with mid-frame BAUD write");
    apbWrite(2'd2, 8'd4);
    apbWrite(2'd3, 8'h01);
    apbWrite(2'd0, 8'hA5);
    fork
      expectTxFrame(8'hA5, 4, 10, "tx_a5", gap);
      begin
        repeat (12) @(negedge clk);
        apbWrite(2'd2, 8'd9);
      end
    join
    readCheck(2'd1, 8'h0A, "tx_a5_status");
    readCheck(2'd2, 8'd9, "baud_after_mid_write");

    $display("[TB] TX frame at BAUD=1 (runs as 2)");
    apbWrite(2'd2, 8'd1);
    apbWrite(2'd0, 8'h3C);
    expectTxFrame(8'h3C, 2, 10, "tx_baud1", gap);
    apbWrite(2'd3, 8'h00);

    $display("[TB] TX FIFO overflow and back-to-back frames");
    bytes5 = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hE7};
    apbWrite(2'd2, 8'd3);
    for (int i = 0; i < 5; i++) apbWrite(2'd0, bytes5[i]);
    readCheck(2'd1, 8'h09, "tx_full_status");
    apbWrite(2'd3, 8'h01);
    for (int i = 0; i < 4; i++) begin
      expectTxFrame(bytes5[i], 3, 10, "tx_b2b", gap);
      if (i > 0) checkOutput("tx_b2b_gap", gap, 0);
    end
    waitTxStart(60, gap, found);
    checkOutput("tx_no_fifth", 32'(found), 32'd0);
    apbWrite(2'd3, 8'h00);

    $display("[TB] RX single frame and interrupt");
    apbWrite(2'd2, 8'd8);
    apbWrite(2'd3, 8'h06);
    sendRxFrame(8'h3C, 8, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("rx_irq_set", 32'(irq), 32'd1);
    readCheck(2'd0, 8'h3C, "rx_data_3c");
    readCheck(2'd0, 8'h00, "rx_data_empty");
    repeat (2) @(negedge clk);
    checkOutput("rx_irq_clr", 32'(irq), 32'd0);

    $display("[TB] RX overrun");
    for (int i = 1; i <= 5; i++) sendRxFrame(8'(i * 8'h11), 8, 1'b1);
    readCheck(2'd1, 8'h16, "ovr_status");
    checkOutput("ovr_irq", 32'(irq), 32'd1);
    for (int i = 1; i <= 4; i++) readCheck(2'd0, 8'(i * 8'h11), "ovr_data");
    readCheck(2'd0, 8'h00, "ovr_data_empty");
    apbWrite(2'd3, 8'h0E);
    readCheck(2'd1, 8'h0A, "ovr_cleared");
    readCheck(2'd3, 8'h06, "ctrl_bit3_reads0");

    $display("[TB] RX frame error and glitch");
    sendRxFrame(8'h5A, 8, 1'b0);
    readCheck(2'd1, 8'h2A, "ferr_status");
    checkOutput("ferr_irq", 32'(irq), 32'd1);
    apbWrite(2'd3, 8'h0E);
    readCheck(2'd1, 8'h0A, "ferr_cleared");
    @(negedge clk); rxSerial = 1'b0;
    @(negedge clk); rxSerial = 1'b1;
    repeat (20) @(negedge clk);
    readCheck(2'd1, 8'h0A, "glitch_status");
    readCheck(2'd0, 8'h00, "glitch_data");
    checkOutput("glitch_irq", 32'(irq), 32'd0);

    $display("[TB] Reset mid TX frame");
    apbWrite(2'd3, 8'h01);
    apbWrite(2'd0, 8'h00);
    waitTxStart(10, gap, found);
    repeat (20) @(negedge clk);
    checkOutput("pre_rst_low", 32'(txSerial), 32'd0);
    #1 rst = 1'b1;
    #1 checkOutput("rst_tx_immediate", 32'(txSerial), 32'd1);
    @(negedge clk); rst = 1'b0;
    readCheck(2'd1, 8'h0A, "post_rst_status");
    readCheck(2'd3, 8'h00, "post_rst_ctrl");
    waitTxStart(100, gap, found);
    checkOutput("post_rst_no_tx", 32'(found), 32'd0);

    $display("[TB] Randomized phase");
    doReset();
    txq.delete();
    rxq.delete();
    mOvr = 1'b0;
    mFe = 1'b0;
    mBaud = 8;
    apbWrite(2'd2, 8'(mBaud));
    apbWrite(2'd3, 8'h06);
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 7);
      data = 8'($urandom);
      case (op)
        0, 1: begin
          apbWrite(2'd0, data);
          if (txq.size() < FIFO_DEPTH) txq.push_back(data);
        end
        2: begin
          apbRead(2'd0, rd);
          if (rxq.size() > 0) exp = rxq.pop_front();
          else exp = 8'h00;
          checkOutput("rnd_data", rd, exp);
        end
        3, 4: begin
          sendRxFrame(data, mBaud, 1'b1);
          if (rxq.size() < FIFO_DEPTH) rxq.push_back(data);
          else mOvr = 1'b1;
        end
        5: begin
          sendRxFrame(data, mBaud, 1'b0);
          mFe = 1'b1;
        end
        6: begin
          apbRead(2'd1, rd);
          checkOutput("rnd_status", rd, modelStatus());
          checkOutput("rnd_irq", 32'(irq), 32'((rxq.size() != 0) | mOvr | mFe));
        end
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            mBaud = $urandom_range(6, 10);
            apbWrite(2'd2, 8'(mBaud));
          end else begin
            apbWrite(2'd3, 8'h0E);
            mOvr = 1'b0;
            mFe = 1'b0;
          end
        end
      endcase
    end
    readCheck(2'd1, modelStatus(), "rnd_final_status");
    while (rxq.size() > 0) begin
      exp = rxq.pop_front();
      readCheck(2'd0, exp, "rnd_drain");
    end
    apbWrite(2'd3, 8'h01);
    foreach (txq[i]) begin
      expectTxFrame(txq[i], mBaud, 10, "rnd_tx", gap);
      if (i > 0) checkOutput("rnd_tx_gap", gap, 0);
    end
    txq.delete();
    readCheck(2'd1, modelStatus(), "rnd_end_status");

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

endmodule
